// File: rtl/artemis_ddr3_port_client_if.sv
// Command/write/read FIFO set of one bidirectional DDR3 controller port.
// The client drives the master side; the controller port model drives the slave side.
interface artemis_ddr3_port_client_if;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_underrun;
  logic        wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    input  cmd_full, wr_full, wr_underrun, wr_error, rd_data, rd_empty, rd_overflow, rd_error
  );
  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    output cmd_full, wr_full, wr_underrun, wr_error, rd_data, rd_empty, rd_overflow, rd_error
  );
endinterface

// File: rtl/artemis_ddr3_port_client.sv
// User-side DDR3 port master: one request becomes a wr-FIFO fill plus command,
// or a command plus rd-FIFO drain onto a valid/ready stream.
module artemis_ddr3_port_client #(
  parameter int MAX_WORDS  = 64,
  parameter int RD_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calibration_done,
  input  logic        req_en,
  input  logic        req_write,
  input  logic [29:0] req_addr,
  input  logic [6:0]  req_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  artemis_ddr3_port_client_if.master ddr
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, FINISH} state_t;

  state_t          state;
  logic [6:0]      cnt;
  logic [6:0]      wcnt;
  logic [TW-1:0]   tcnt;
  logic            fault;
  logic            bad_req;

  assign fault   = ddr.wr_underrun | ddr.wr_error | ddr.rd_overflow | ddr.rd_error;
  assign bad_req = (req_addr[1:0] != 2'b00) || (req_count == 7'd0) ||
                   (int'(req_count) > MAX_WORDS);

  // FINISH is the done cycle, so busy is already low there.
  assign busy = (state != IDLE) && (state != FINISH);

  // A fault in the command cycle must not let the push through.
  assign ddr.cmd_en        = ((state == WR_CMD) || (state == RD_CMD)) && !ddr.cmd_full && !fault;
  assign wdata_ready       = (state == WR_FILL) && !ddr.wr_full;
  assign ddr.wr_en         = wdata_ready && wdata_valid;
  assign ddr.wr_data       = wdata;
  assign ddr.wr_mask       = 4'b0000;
  assign rdata             = ddr.rd_data;
  assign rdata_valid       = (state == RD_DRAIN) && !ddr.rd_empty;
  assign ddr.rd_en         = rdata_valid && rdata_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      wcnt              <= '0;
      tcnt              <= '0;
      done              <= 1'b0;
      error             <= 1'b0;
      ddr.cmd_instr     <= '0;
      ddr.cmd_bl        <= '0;
      ddr.cmd_byte_addr <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (busy && fault) begin
        error <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (req_en && calibration_done) begin
            cnt               <= req_count;
            wcnt              <= '0;
            tcnt              <= '0;
            ddr.cmd_instr     <= req_write ? 3'b000 : 3'b001;
            ddr.cmd_bl        <= 6'(req_count - 7'd1);
            ddr.cmd_byte_addr <= req_addr;
            if (bad_req) error <= 1'b1;
            else         state <= req_write ? WR_FILL : RD_CMD;
          end
          WR_FILL: if (ddr.wr_en) begin
            wcnt <= wcnt + 7'd1;
            if (wcnt + 7'd1 == cnt) state <= WR_CMD;
          end
          WR_CMD: if (ddr.cmd_en) begin
            state <= FINISH;
            done  <= 1'b1;
          end
          RD_CMD: if (ddr.cmd_en) begin
            state <= RD_DRAIN;
            wcnt  <= '0;
            tcnt  <= '0;
          end
          RD_DRAIN: if (ddr.rd_en) begin
            wcnt <= wcnt + 7'd1;
            tcnt <= '0;
            if (wcnt + 7'd1 == cnt) begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end else if (ddr.rd_empty) begin
            // Registered error lands exactly RD_TIMEOUT cycles after the command push cycle.
            if (tcnt == TW'(RD_TIMEOUT - 2)) begin
              error <= 1'b1;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_artemis_ddr3_port_client.sv
// Directed + randomized bench: FIFO/stream responders, event logs and a transaction-level model.
module tb_artemis_ddr3_port_client;
  localparam int MAXW = 64;
  localparam int RDTO = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        calibration_done, req_en, req_write;
  logic [29:0] req_addr;
  logic [6:0]  req_count;
  logic        busy, done, error;
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready = 1'b1;

  artemis_ddr3_port_client_if ddr();

  artemis_ddr3_port_client #(.MAX_WORDS(MAXW), .RD_TIMEOUT(RDTO)) dut (
    .clk(clk), .rst(rst), .calibration_done(calibration_done),
    .req_en(req_en), .req_write(req_write), .req_addr(req_addr), .req_count(req_count),
    .busy(busy), .done(done), .error(error),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .ddr(ddr.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event logs captured mid-cycle.
  int          cyc = 0, done_cnt = 0, err_cnt = 0, overlap = 0, busy_done = 0;
  int          acc_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [2:0]  cmd_i_q[$];
  logic [5:0]  cmd_b_q[$];
  logic [29:0] cmd_a_q[$];
  int          cmd_c_q[$];

  // Responder state: write source, rd FIFO contents, stall knobs.
  logic [31:0] wsrc[$];
  logic [31:0] rsrc[$];
  logic [31:0] rd_q[$];
  logic [31:0] xq[$];
  bit          w_pop = 0, r_pop = 0, rd_autofill = 1;
  bit          wgap_en = 0, rgap_en = 0, wfull_rand = 0;
  int          rrdy_mode = 0;

  int s_done, s_err, s_wr, s_rd, s_cmd;

  always @(negedge clk) begin
    cyc++;
    if (req_en && calibration_done) acc_cyc = cyc;
    if (ddr.wr_en) wr_log.push_back(ddr.wr_data);
    if (rdata_valid && rdata_ready) rd_log.push_back(rdata);
    if (ddr.cmd_en) begin
      cmd_i_q.push_back(ddr.cmd_instr);
      cmd_b_q.push_back(ddr.cmd_bl);
      cmd_a_q.push_back(ddr.cmd_byte_addr);
      cmd_c_q.push_back(cyc);
      if (ddr.cmd_instr == 3'b001 && rd_autofill)
        foreach (rsrc[i]) rd_q.push_back(rsrc[i]);
    end
    if (done)  begin done_cnt++; done_cyc = cyc; end
    if (error) begin err_cnt++;  err_cyc  = cyc; end
    if (done && error) overlap++;
    if (done && busy)  busy_done++;
    w_pop = wdata_valid && wdata_ready;
    r_pop = ddr.rd_en;
  end

  always @(posedge clk) begin
    #1;
    if (w_pop && wsrc.size() > 0) void'(wsrc.pop_front());
    if (r_pop && rd_q.size() > 0) void'(rd_q.pop_front());
    w_pop = 0;
    r_pop = 0;
    wdata_valid  = (wsrc.size() > 0) && !(wgap_en && $urandom_range(0, 3) == 0);
    wdata        = (wsrc.size() > 0) ? wsrc[0] : 32'h0;
    ddr.rd_empty = (rd_q.size() == 0) || (rgap_en && $urandom_range(0, 3) == 0);
    ddr.rd_data  = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
    ddr.wr_full  = wfull_rand && ($urandom_range(0, 3) == 0);
    case (rrdy_mode)
      0:       rdata_ready = 1'b1;
      1:       rdata_ready = ~rdata_ready;
      default: rdata_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [29:0] a, input logic [6:0] n);
    tick();
    s_done = done_cnt; s_err = err_cnt; s_wr = wr_log.size();
    s_rd = rd_log.size(); s_cmd = cmd_i_q.size();
    req_en = 1'b1; req_write = wr; req_addr = a; req_count = n;
    tick();
    req_en = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != s_done || err_cnt != s_err) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  // Model: n accepted words equal to the source, one cmd {000, n-1, addr}, one done.
  task automatic run_write(input string tag, input logic [29:0] a, input bit stall, input bit clean);
    bit ok;
    int n;
    n = xq.size();
    wfull_rand = stall; wgap_en = stall;
    foreach (xq[i]) wsrc.push_back(xq[i]);
    do_req(1'b1, a, 7'(n));
    wait_end(n * 12 + 40, ok);
    chk({tag, "_finished"}, 64'(ok), 64'd1);
    chk({tag, "_nwords"}, 64'(wr_log.size() - s_wr), 64'(n));
    for (int i = 0; i < n && s_wr + i < wr_log.size(); i++)
      chk($sformatf("%s_wd%0d", tag, i), 64'(wr_log[s_wr + i]), 64'(xq[i]));
    chk({tag, "_ncmd"}, 64'(cmd_i_q.size() - s_cmd), 64'd1);
    if (cmd_i_q.size() > s_cmd) begin
      chk({tag, "_instr"}, 64'(cmd_i_q[s_cmd]), 64'd0);
      chk({tag, "_bl"},    64'(cmd_b_q[s_cmd]), 64'(n - 1));
      chk({tag, "_addr"},  64'(cmd_a_q[s_cmd]), 64'(a));
    end
    chk({tag, "_done"}, 64'(done_cnt - s_done), 64'd1);
    chk({tag, "_err"},  64'(err_cnt - s_err),   64'd0);
    if (clean) chk({tag, "_latency"}, 64'(done_cyc - acc_cyc), 64'(n + 2));
    wfull_rand = 0; wgap_en = 0;
    tick();
  endtask

  // Model: stream carries rsrc in order, one cmd {001, n-1, addr} the cycle after acceptance.
  task automatic run_read(input string tag, input logic [29:0] a, input bit gaps, input int rmode);
    bit ok;
    int n;
    n = rsrc.size();
    rgap_en = gaps; rrdy_mode = rmode;
    do_req(1'b0, a, 7'(n));
    wait_end(n * 30 + 60, ok);
    chk({tag, "_finished"}, 64'(ok), 64'd1);
    chk({tag, "_nwords"}, 64'(rd_log.size() - s_rd), 64'(n));
    for (int i = 0; i < n && s_rd + i < rd_log.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), 64'(rd_log[s_rd + i]), 64'(rsrc[i]));
    chk({tag, "_ncmd"}, 64'(cmd_i_q.size() - s_cmd), 64'd1);
    if (cmd_i_q.size() > s_cmd) begin
      chk({tag, "_instr"},   64'(cmd_i_q[s_cmd]), 64'd1);
      chk({tag, "_bl"},      64'(cmd_b_q[s_cmd]), 64'(n - 1));
      chk({tag, "_addr"},    64'(cmd_a_q[s_cmd]), 64'(a));
      chk({tag, "_cmd_lat"}, 64'(cmd_c_q[s_cmd] - acc_cyc), 64'd1);
    end
    chk({tag, "_done"},     64'(done_cnt - s_done), 64'd1);
    chk({tag, "_err"},      64'(err_cnt - s_err),   64'd0);
    chk({tag, "_fifo_left"}, 64'(rd_q.size()),      64'd0);
    rgap_en = 0; rrdy_mode = 0;
    tick();
  endtask

  initial begin
    logic [29:0] bad_a[3];
    logic [6:0]  bad_n[3];
    bit          ok;
    int          n;
    rst = 1'b0; calibration_done = 1'b0; req_en = 1'b0; req_write = 1'b0;
    req_addr = '0; req_count = '0;
    ddr.cmd_full = 1'b0; ddr.wr_underrun = 1'b0; ddr.wr_error = 1'b0;
    ddr.rd_overflow = 1'b0; ddr.rd_error = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", 64'({done, error}), 64'd0);
    chk("rst_strobes", 64'({ddr.cmd_en, ddr.wr_en, ddr.rd_en, wdata_ready, rdata_valid}), 64'd0);
    chk("rst_cmd_fields", 64'({ddr.cmd_instr, ddr.cmd_bl, ddr.cmd_byte_addr}), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Calibration not done: request ignored
    do_req(1'b1, 30'h100, 7'd4);
    repeat (5) tick();
    chk("nocal_busy", 64'(busy), 64'd0);
    chk("nocal_events", 64'((done_cnt - s_done) + (err_cnt - s_err) + (cmd_i_q.size() - s_cmd)), 64'd0);
    calibration_done = 1'b1;
    tick();

    // Directed write, then directed read with toggling ready
    xq = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_write("wr4", 30'h100, 1'b0, 1'b1);
    rsrc = {};
    for (int i = 0; i < 8; i++) rsrc.push_back(32'h10 + 32'(i));
    run_read("rd8", 30'h2000, 1'b0, 1);

    // cmd_full held for 5 cycles of WR_CMD
    n = $urandom_range(1, 6);
    xq = {};
    for (int i = 0; i < n; i++) xq.push_back($urandom);
    foreach (xq[i]) wsrc.push_back(xq[i]);
    ddr.cmd_full = 1'b1;
    do_req(1'b1, 30'h400, 7'(n));
    repeat (n + 5) tick();
    chk("cfull_held_nocmd", 64'(cmd_i_q.size() - s_cmd), 64'd0);
    ddr.cmd_full = 1'b0;
    wait_end(20, ok);
    chk("cfull_finished", 64'(ok), 64'd1);
    chk("cfull_ncmd", 64'(cmd_i_q.size() - s_cmd), 64'd1);
    if (cmd_i_q.size() > s_cmd) chk("cfull_cmd_cyc", 64'(cmd_c_q[s_cmd] - acc_cyc), 64'(n + 6));
    chk("cfull_done_cyc", 64'(done_cyc - acc_cyc), 64'(n + 7));
    tick();

    // Rejected requests
    bad_a = '{30'h3, 30'h100, 30'h100};
    bad_n = '{7'd4, 7'd0, 7'd65};
    for (int k = 0; k < 3; k++) begin
      do_req(1'($urandom_range(0, 1)), bad_a[k], bad_n[k]);
      wait_end(10, ok);
      chk($sformatf("bad%0d_finished", k), 64'(ok), 64'd1);
      chk($sformatf("bad%0d_err_cyc", k), 64'(err_cyc - acc_cyc), 64'd1);
      chk($sformatf("bad%0d_counts", k),
          64'({16'(err_cnt - s_err), 16'(done_cnt - s_done), 16'(cmd_i_q.size() - s_cmd),
               8'(wr_log.size() - s_wr), 8'(rd_log.size() - s_rd)}),
          64'({16'd1, 16'd0, 16'd0, 8'd0, 8'd0}));
      tick();
      chk($sformatf("bad%0d_busy", k), 64'(busy), 64'd0);
    end

    // Largest legal write
    xq = {};
    for (int i = 0; i < MAXW; i++) xq.push_back($urandom);
    run_write("wrmax", 30'h8000, 1'b0, 1'b1);

    // Randomized writes and reads with FIFO/stream back-pressure
    for (int t = 0; t < 3; t++) begin
      xq = {};
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) xq.push_back($urandom);
      run_write($sformatf("rwr%0d", t), 30'($urandom) & ~30'h3, 1'b1, 1'b0);
      rsrc = {};
      n = $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) rsrc.push_back($urandom);
      run_read($sformatf("rrd%0d", t), 30'($urandom) & ~30'h3, 1'b1, 2);
    end

    // Read timeout with rd_empty stuck high
    rd_autofill = 0;
    do_req(1'b0, 30'h40, 7'd4);
    wait_end(RDTO + 100, ok);
    chk("tmo_finished", 64'(ok), 64'd1);
    chk("tmo_err", 64'(err_cnt - s_err), 64'd1);
    chk("tmo_nodone", 64'(done_cnt - s_done), 64'd0);
    if (cmd_i_q.size() > s_cmd) chk("tmo_err_cyc", 64'(err_cyc - cmd_c_q[s_cmd]), 64'(RDTO));
    tick();
    chk("tmo_busy", 64'(busy), 64'd0);
    rd_autofill = 1;

    // Fault flag while waiting on cmd_full: error, never a command
    xq = {32'h5A5A5A5A};
    wsrc.push_back(xq[0]);
    ddr.cmd_full = 1'b1;
    do_req(1'b1, 30'h600, 7'd1);
    repeat (2) tick();
    ddr.rd_error = 1'b1;
    tick();
    ddr.rd_error = 1'b0;
    ddr.cmd_full = 1'b0;
    repeat (5) tick();
    chk("flt_err", 64'(err_cnt - s_err), 64'd1);
    chk("flt_err_cyc", 64'(err_cyc - acc_cyc), 64'd4);
    chk("flt_nocmd_nodone", 64'((cmd_i_q.size() - s_cmd) + (done_cnt - s_done)), 64'd0);
    chk("flt_busy", 64'(busy), 64'd0);

    // Fault coinciding with the final read beat: error wins
    rsrc = {32'hCAFE0001};
    do_req(1'b0, 30'h700, 7'd1);
    tick();
    ddr.rd_overflow = 1'b1;
    tick();
    ddr.rd_overflow = 1'b0;
    repeat (3) tick();
    chk("coin_err", 64'(err_cnt - s_err), 64'd1);
    chk("coin_nodone", 64'(done_cnt - s_done), 64'd0);
    rd_q.delete();
    tick();

    // Reset during WR_FILL after 2 of 6 words
    xq = {};
    for (int i = 0; i < 6; i++) xq.push_back($urandom);
    foreach (xq[i]) wsrc.push_back(xq[i]);
    do_req(1'b1, 30'h300, 7'd6);
    repeat (2) tick();
    chk("mrst_two_words", 64'(wr_log.size() - s_wr), 64'd2);
    rst = 1'b0;
    #1;
    chk("mrst_outs", 64'({busy, done, error, ddr.cmd_en, ddr.wr_en, ddr.rd_en, wdata_ready, rdata_valid}), 64'd0);
    chk("mrst_cmd_fields", 64'({ddr.cmd_instr, ddr.cmd_bl, ddr.cmd_byte_addr}), 64'd0);
    tick();
    wsrc.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("mrst_nocmd", 64'(cmd_i_q.size() - s_cmd), 64'd0);
    chk("mrst_nomore_words", 64'(wr_log.size() - s_wr), 64'd2);
    xq = {32'h0BADF00D};
    run_write("post_rst_wr1", 30'h10, 1'b0, 1'b1);

    chk("done_err_overlap", 64'(overlap), 64'd0);
    chk("busy_during_done", 64'(busy_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
